// File: rtl/sfr_arbiter.sv
// Round-robin arbiter that shares one spi_flash_read engine between the CPU
// flash window (port 0) and the video prefetcher (port 1), with a stall watchdog.
module sfr_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_cpu,
  input  logic              n_reset,

  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [CNT_W-1:0]  req0_word_count,
  output logic              req0_strobe,
  output logic [31:0]       req0_data,
  output logic              req0_done,
  output logic              req0_error,

  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [CNT_W-1:0]  req1_word_count,
  output logic              req1_strobe,
  output logic [31:0]       req1_data,
  output logic              req1_done,
  output logic              req1_error,

  output logic              sfr_start,
  output logic [ADDR_W-1:0] sfr_address,
  output logic [CNT_W-1:0]  sfr_word_count,
  input  logic              sfr_strobe,
  input  logic              sfr_done,
  input  logic [31:0]       sfr_data_out
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              owner;
  logic              last_grant;
  logic [WD_W-1:0]   watchdog;
  logic              grant;
  logic              grant_port;
  logic              busy;
  logic              timeout;
  logic [ADDR_W-1:0] grant_address;
  logic [CNT_W-1:0]  grant_count_raw;
  logic [CNT_W-1:0]  grant_count;

  // A stall is declared only when neither a strobe nor done lands on the limit cycle.
  always_comb begin
    state_next      = state;
    grant           = 1'b0;
    grant_port      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    busy            = n_reset && (state == BUSY);
    timeout         = busy && (watchdog == WD_LIMIT) && !sfr_strobe && !sfr_done;
    grant_address   = grant_port ? req1_address : req0_address;
    grant_count_raw = grant_port ? req1_word_count : req0_word_count;
    grant_count     = (grant_count_raw == '0) ? CNT_W'(1) : grant_count_raw;

    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (sfr_done || timeout) begin
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (!n_reset) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      sfr_address    <= '0;
      sfr_word_count <= '0;
      watchdog       <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner          <= grant_port;
        last_grant     <= grant_port;
        sfr_address    <= grant_address;
        sfr_word_count <= grant_count;
      end
      if ((state == BUSY) && !sfr_strobe) begin
        watchdog <= watchdog + WD_W'(1);
      end else begin
        watchdog <= '0;
      end
    end
  end

  // Reader-side events reach only the current owner, and only while busy.
  assign sfr_start   = (state == BUSY);
  assign req0_strobe = busy && sfr_strobe && !owner;
  assign req1_strobe = busy && sfr_strobe && owner;
  assign req0_done   = busy && sfr_done && !owner;
  assign req1_done   = busy && sfr_done && owner;
  assign req0_error  = timeout && !owner;
  assign req1_error  = timeout && owner;
  assign req0_data   = sfr_data_out;
  assign req1_data   = sfr_data_out;

endmodule

// File: tb/tb_sfr_arbiter.sv
// Self-checking bench for sfr_arbiter: vector table of grants plus hand-written
// watchdog, coincidence and reset sequences; strobes are checked via a scoreboard.
module tb_sfr_arbiter;

  localparam int ADDR_W  = 24;
  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 16;

  logic              clk_cpu;
  logic              n_reset;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_address;
  logic [CNT_W-1:0]  req0_word_count;
  logic              req0_strobe;
  logic [31:0]       req0_data;
  logic              req0_done;
  logic              req0_error;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_address;
  logic [CNT_W-1:0]  req1_word_count;
  logic              req1_strobe;
  logic [31:0]       req1_data;
  logic              req1_done;
  logic              req1_error;
  logic              sfr_start;
  logic [ADDR_W-1:0] sfr_address;
  logic [CNT_W-1:0]  sfr_word_count;
  logic              sfr_strobe;
  logic              sfr_done;
  logic [31:0]       sfr_data_out;

  int checkCount = 0;
  int errorCount = 0;
  int doneSeen[2];
  int errSeen[2];
  int expDone[2];
  logic [32:0] sbQueue[$];

  typedef struct {
    logic              v0;
    logic              v1;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [CNT_W-1:0]  c0;
    logic [CNT_W-1:0]  c1;
    int                expPort;
    logic [ADDR_W-1:0] expAddr;
    logic [CNT_W-1:0]  expCnt;
  } vec_t;

  vec_t vecs[8];

  sfr_arbiter #(
    .ADDR_W(ADDR_W),
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_cpu(clk_cpu),
    .n_reset(n_reset),
    .req0_valid(req0_valid),
    .req0_address(req0_address),
    .req0_word_count(req0_word_count),
    .req0_strobe(req0_strobe),
    .req0_data(req0_data),
    .req0_done(req0_done),
    .req0_error(req0_error),
    .req1_valid(req1_valid),
    .req1_address(req1_address),
    .req1_word_count(req1_word_count),
    .req1_strobe(req1_strobe),
    .req1_data(req1_data),
    .req1_done(req1_done),
    .req1_error(req1_error),
    .sfr_start(sfr_start),
    .sfr_address(sfr_address),
    .sfr_word_count(sfr_word_count),
    .sfr_strobe(sfr_strobe),
    .sfr_done(sfr_done),
    .sfr_data_out(sfr_data_out)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                               input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1);
    req0_valid      = v0;
    req1_valid      = v1;
    req0_address    = a0;
    req1_address    = a1;
    req0_word_count = c0;
    req1_word_count = c1;
  endtask

  task automatic waitStart(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!sfr_start && cycles < 8);
    if (!sfr_start) checkOutput("start_timeout", sfr_start, 1);
  endtask

  // Streams the data words, finishes with done, then walks through RELEASE and IDLE.
  task automatic runTxn(input int port, input int words);
    logic        pb;
    logic [31:0] d;
    pb = (port == 1);
    for (int w = 0; w < words; w++) begin
      d            = $urandom;
      sfr_data_out = d;
      sfr_strobe   = 1'b1;
      sbQueue.push_back({pb, d});
      tick();
    end
    sfr_strobe = 1'b0;
    sfr_done   = 1'b1;
    #1;
    checkOutput("done_owner", pb ? req1_done : req0_done, 1);
    checkOutput("done_other", pb ? req0_done : req1_done, 0);
    expDone[port]++;
    tick();
    sfr_done = 1'b0;
    checkOutput("release_start", sfr_start, 0);
    if (pb) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    sfr_strobe = 1'b1;
    #1;
    checkOutput("release_ignore", {req0_strobe, req1_strobe}, 0);
    sfr_strobe = 1'b0;
    tick();
    checkOutput("idle_start", sfr_start, 0);
  endtask

  task automatic resetDut();
    n_reset = 1'b0;
    applyStimulus(0, 0, '0, '0, '0, '0);
    sfr_strobe   = 1'b0;
    sfr_done     = 1'b0;
    sfr_data_out = '0;
    tick();
    tick();
    checkOutput("reset_start", sfr_start, 0);
    checkOutput("reset_address", sfr_address, 0);
    checkOutput("reset_count", sfr_word_count, 0);
    checkOutput("reset_outputs", {req0_strobe, req1_strobe, req0_done, req1_done,
                                  req0_error, req1_error}, 0);
    n_reset = 1'b1;
    tick();
  endtask

  // Every routed strobe must match the oldest word the bench issued.
  always @(negedge clk_cpu) begin
    logic [32:0] exp;
    if (req0_strobe || req1_strobe) begin
      checkOutput("strobe_exclusive", req0_strobe & req1_strobe, 0);
      checkOutput("strobe_expected", sbQueue.size() != 0, 1);
      if (sbQueue.size() != 0) begin
        exp = sbQueue.pop_front();
        checkOutput("strobe_port", req1_strobe, exp[32]);
        checkOutput("strobe_data", req1_strobe ? req1_data : req0_data, exp[31:0]);
      end
    end
    if (req0_done) doneSeen[0]++;
    if (req1_done) doneSeen[1]++;
    if (req0_error) errSeen[0]++;
    if (req1_error) errSeen[1]++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int lat;

    vecs[0] = '{1, 1, 24'h001000, 24'h002000, 24'd2, 24'd3, 0, 24'h001000, 24'd2};
    vecs[1] = '{0, 1, 24'h000000, 24'h002000, 24'd0, 24'd3, 1, 24'h002000, 24'd3};
    vecs[2] = '{1, 1, 24'h003000, 24'h004000, 24'd1, 24'd2, 0, 24'h003000, 24'd1};
    vecs[3] = '{0, 1, 24'h000000, 24'h004400, 24'd0, 24'd4, 1, 24'h004400, 24'd4};
    vecs[4] = '{1, 0, 24'h005000, 24'h000000, 24'd0, 24'd0, 0, 24'h005000, 24'd1};
    vecs[5] = '{1, 0, 24'hFFFFFF, 24'h000000, 24'd2, 24'd0, 0, 24'hFFFFFF, 24'd2};
    vecs[6] = '{1, 1, 24'h006000, 24'h007000, 24'd1, 24'd1, 1, 24'h007000, 24'd1};
    vecs[7] = '{1, 0, 24'h008000, 24'h000000, 24'd3, 24'd0, 0, 24'h008000, 24'd3};

    // Single read from reset with one-cycle grant latency.
    resetDut();
    applyStimulus(1, 0, 24'h000100, '0, 24'd1, '0);
    tick();
    checkOutput("t1_start", sfr_start, 1);
    checkOutput("t1_address", sfr_address, 24'h000100);
    checkOutput("t1_count", sfr_word_count, 1);
    sfr_data_out = 32'hDEADBEEF;
    sfr_strobe   = 1'b1;
    sbQueue.push_back({1'b0, 32'hDEADBEEF});
    #1;
    checkOutput("t1_strobe0", req0_strobe, 1);
    checkOutput("t1_strobe1", req1_strobe, 0);
    checkOutput("t1_data0", req0_data, 32'hDEADBEEF);
    checkOutput("t1_data1", req1_data, 32'hDEADBEEF);
    tick();
    runTxn(0, 0);

    // Round-robin sequence from a fresh reset.
    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].a1, vecs[i].c0, vecs[i].c1);
      waitStart(lat);
      checkOutput("grant_latency", lat, 1);
      checkOutput("grant_address", sfr_address, vecs[i].expAddr);
      checkOutput("grant_count", sfr_word_count, vecs[i].expCnt);
      runTxn(vecs[i].expPort, int'(vecs[i].expCnt));
    end

    // Stalled reader: error fires in the last watchdog cycle.
    applyStimulus(1, 0, 24'h009000, '0, 24'd2, '0);
    waitStart(lat);
    for (int k = 0; k < TIMEOUT; k++) begin
      checkOutput("wd_error", req0_error, k == TIMEOUT - 1);
      tick();
    end
    checkOutput("wd_release_start", sfr_start, 0);
    req0_valid = 1'b0;
    tick();
    applyStimulus(0, 1, '0, 24'h00A000, '0, 24'd2);
    waitStart(lat);
    checkOutput("wd_next_latency", lat, 1);
    checkOutput("wd_next_address", sfr_address, 24'h00A000);
    runTxn(1, 2);

    // Strobe restarts the watchdog; done on the limit cycle beats the timeout.
    applyStimulus(1, 0, 24'h00B000, '0, 24'd1, '0);
    waitStart(lat);
    repeat (TIMEOUT - 2) tick();
    sfr_data_out = 32'h12345678;
    sfr_strobe   = 1'b1;
    sbQueue.push_back({1'b0, 32'h12345678});
    tick();
    sfr_strobe = 1'b0;
    repeat (TIMEOUT - 1) tick();
    sfr_done = 1'b1;
    #1;
    checkOutput("coincide_error", req0_error, 0);
    checkOutput("coincide_done", req0_done, 1);
    runTxn(0, 0);

    // Reader events while idle are not routed.
    sfr_strobe = 1'b1;
    sfr_done   = 1'b1;
    #1;
    checkOutput("idle_ignore", {req0_strobe, req1_strobe, req0_done, req1_done}, 0);
    tick();
    sfr_strobe = 1'b0;
    sfr_done   = 1'b0;
    tick();

    // Reset mid-transaction, then arbitration restarts from port 0.
    applyStimulus(1, 0, 24'h00C000, '0, 24'd4, '0);
    waitStart(lat);
    sfr_data_out = 32'hCAFEF00D;
    sfr_strobe   = 1'b1;
    sbQueue.push_back({1'b0, 32'hCAFEF00D});
    tick();
    n_reset  = 1'b0;
    sfr_done = 1'b1;
    #1;
    checkOutput("inreset_outputs", {req0_strobe, req1_strobe, req0_done, req1_done}, 0);
    tick();
    checkOutput("midreset_start", sfr_start, 0);
    checkOutput("midreset_address", sfr_address, 0);
    n_reset    = 1'b1;
    sfr_strobe = 1'b0;
    sfr_done   = 1'b0;
    applyStimulus(1, 1, 24'hABCDEF, 24'h00D000, 24'd0, 24'd1);
    waitStart(lat);
    req1_valid = 1'b0;
    checkOutput("postreset_address", sfr_address, 24'hABCDEF);
    checkOutput("postreset_count", sfr_word_count, 1);
    runTxn(0, 1);

    tick();
    checkOutput("done_count0", doneSeen[0], expDone[0]);
    checkOutput("done_count1", doneSeen[1], expDone[1]);
    checkOutput("error_count0", errSeen[0], 1);
    checkOutput("error_count1", errSeen[1], 0);
    checkOutput("scoreboard_drained", sbQueue.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
